// File: rtl/add_pkg.sv
// Shared definitions for the burst accumulator: default width, FSM state encoding
// and operation encoding.
package add_pkg;

  localparam int WIDTH_DEF = 6;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/acc_adder.sv
// Stateless signed adder with carry-in; overflow is set when the exact
// result of a + b + cin does not fit in WIDTH signed bits.
module acc_adder #(
  parameter int WIDTH = add_pkg::WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    cin,
  output logic signed [WIDTH-1:0] sum,
  output logic                    overflow
);

  logic [WIDTH:0] sum_ext;

  // One guard bit: the exact result fits iff the two top bits agree.
  always_comb begin
    sum_ext  = {a[WIDTH-1], a} + {b[WIDTH-1], b} + {{WIDTH{1'b0}}, cin};
    sum      = sum_ext[WIDTH-1:0];
    overflow = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
  end

endmodule

// File: rtl/acc_unit.sv
// Burst accumulator: adds or subtracts signed beats until in_last, then holds
// the wrapped sum, sticky overflow and saturating beat count until consumed.
module acc_unit
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_op,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_sum,
  output logic                    out_overflow,
  output logic [CNT_W-1:0]        out_count
);

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] acc_p1;
  logic                    sticky_p1;
  logic [CNT_W-1:0]        cnt_p1;

  logic signed [WIDTH-1:0] add_b;
  logic signed [WIDTH-1:0] add_sum;
  logic                    add_cin;
  logic                    add_ovf;
  logic                    accept;
  logic                    release_hold;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  // Subtraction reuses the adder as acc + ~in_data + 1.
  always_comb begin
    add_cin = (in_op == OP_SUB);
    add_b   = add_cin ? ~in_data : in_data;
  end

  acc_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (acc_p1),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  assign accept       = in_ready && in_valid;
  assign release_hold = out_valid && out_ready;

  // Stage p1: accumulator, sticky overflow and beat count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1    <= '0;
      sticky_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else if (accept) begin
      acc_p1    <= add_sum;
      sticky_p1 <= sticky_p1 | add_ovf;
      cnt_p1    <= cnt_sat_inc(cnt_p1);
    end else if (release_hold) begin
      acc_p1    <= '0;
      sticky_p1 <= 1'b0;
      cnt_p1    <= '0;
    end
  end

  assign out_sum      = acc_p1;
  assign out_overflow = sticky_p1;
  assign out_count    = cnt_p1;

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit (WIDTH=6, CNT_W=4): directed bursts plus
// randomized bursts checked against an integer reference model.
module tb_acc_unit;

  localparam int W  = 6;
  localparam int CW = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_data = '0;
  logic                in_op = 1'b0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_sum;
  logic                out_overflow;
  logic [CW-1:0]       out_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: exact-arithmetic view of the burst
  int m_acc = 0;
  int m_ovf = 0;
  int m_cnt = 0;

  acc_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_op        (in_op),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  function automatic int wrap_w(input int x);
    int r;
    r = ((x % 64) + 64) % 64;
    if (r >= 32) r = r - 64;
    return r;
  endfunction

  task automatic model_clear();
    m_acc = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_beat(input int op, input int d);
    int exact;
    exact = (op != 0) ? m_acc - d : m_acc + d;
    if (exact > 31 || exact < -32) m_ovf = 1;
    m_acc = wrap_w(exact);
    m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
  endtask

  // Drive one beat at a negedge; it is taken at the following posedge.
  task automatic beat(input int op, input int d, input logic last);
    in_valid = 1'b1; in_op = op[0]; in_data = W'(d); in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_op = 1'b0; in_data = '0; in_last = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== 6'sd0) begin n_err++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
    n_cmp++; if (out_overflow !== 1'b0) begin n_err++; $display("FAIL reset_out_overflow got %b want 0", out_overflow); end
    n_cmp++; if (out_count !== 4'd0) begin n_err++; $display("FAIL reset_out_count got %0d want 0", out_count); end
  endtask

  int dir_len [4] = '{3, 3, 2, 1};
  int dir_op  [4][3] = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 1, 0}, '{1, 0, 0}};
  int dir_d   [4][3] = '{'{10, 15, 6}, '{31, 1, -1}, '{-32, 1, 0}, '{-32, 0, 0}};
  int dir_sum [4] = '{31, 31, 31, -32};
  int dir_ovf [4] = '{0, 1, 1, 1};
  int dir_cnt [4] = '{3, 3, 2, 1};

  task automatic test_directed();
    logic signed [W-1:0] es;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < dir_len[c]; b++) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_early_valid got %b want 0", c, out_valid); end
        beat(dir_op[c][b], dir_d[c][b], b == dir_len[c] - 1);
      end
      es = W'(dir_sum[c]);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_out_valid got %b want 1", c, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL dir%0d_in_ready got %b want 0", c, in_ready); end
      n_cmp++; if (out_sum !== es) begin n_err++; $display("FAIL dir%0d_sum got %0d want %0d", c, out_sum, es); end
      n_cmp++; if (out_overflow !== dir_ovf[c][0]) begin n_err++; $display("FAIL dir%0d_ovf got %b want %0d", c, out_overflow, dir_ovf[c]); end
      n_cmp++; if (out_count !== CW'(dir_cnt[c])) begin n_err++; $display("FAIL dir%0d_cnt got %0d want %0d", c, out_count, dir_cnt[c]); end
      release_result();
    end
  endtask

  task automatic test_hold();
    beat(0, 1, 1'b0);
    beat(0, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 6'sd7; in_last = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_in_ready got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold%0d_out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (out_sum !== 6'sd3 || out_count !== 4'd2 || out_overflow !== 1'b0)
        begin n_err++; $display("FAIL hold%0d_stable got sum=%0d cnt=%0d ovf=%b want 3/2/0", i, out_sum, out_count, out_overflow); end
    end
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    release_result();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_sum !== 6'sd0 || out_count !== 4'd0) begin n_err++; $display("FAIL hold_release_clear got sum=%0d cnt=%0d want 0/0", out_sum, out_count); end
    beat(0, 4, 1'b1);
    n_cmp++; if (out_sum !== 6'sd4 || out_count !== 4'd1) begin n_err++; $display("FAIL hold_next_burst got sum=%0d cnt=%0d want 4/1", out_sum, out_count); end
    release_result();
  endtask

  task automatic test_reset_mid();
    beat(0, 5, 1'b0);
    beat(0, 7, 1'b0);
    n_cmp++; if (out_sum !== 6'sd12 || out_count !== 4'd2) begin n_err++; $display("FAIL mid_running got sum=%0d cnt=%0d want 12/2", out_sum, out_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_sum !== 6'sd0 || out_count !== 4'd0 || out_overflow !== 1'b0)
      begin n_err++; $display("FAIL mid_async_clear got sum=%0d cnt=%0d ovf=%b want 0/0/0", out_sum, out_count, out_overflow); end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_hs got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    @(negedge clk); rst_n = 1'b1;
    beat(0, 3, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 6'sd3 || out_count !== 4'd1)
      begin n_err++; $display("FAIL mid_fresh got vld=%b sum=%0d cnt=%0d want 1/3/1", out_valid, out_sum, out_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 6'sd0)
      begin n_err++; $display("FAIL hold_async_clear got vld=%b rdy=%b sum=%0d want 0/1/0", out_valid, in_ready, out_sum); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) beat(0, 0, i == 19);
    n_cmp++; if (out_count !== 4'd15) begin n_err++; $display("FAIL sat_count got %0d want 15", out_count); end
    n_cmp++; if (out_sum !== 6'sd0 || out_overflow !== 1'b0) begin n_err++; $display("FAIL sat_sum got sum=%0d ovf=%b want 0/0", out_sum, out_overflow); end
    release_result();
  endtask

  task automatic test_random();
    int len, op, d, gap, stall;
    logic signed [W-1:0] es;
    for (int k = 0; k < 40; k++) begin
      model_clear();
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_data = W'($urandom); in_op = $urandom_range(0, 1);
          @(negedge clk);
          es = W'(m_acc);
          n_cmp++; if (in_ready !== 1'b1 || out_sum !== es || out_count !== CW'(m_cnt))
            begin n_err++; $display("FAIL rnd%0d_idle got rdy=%b sum=%0d cnt=%0d want 1/%0d/%0d", k, in_ready, out_sum, out_count, es, m_cnt); end
        end
        op = $urandom_range(0, 1);
        case ($urandom_range(0, 7))
          0: d = -32;
          1: d = 31;
          default: d = int'($urandom_range(0, 63)) - 32;
        endcase
        beat(op, d, b == len - 1);
        model_beat(op, d);
      end
      es = W'(m_acc);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== es || out_overflow !== m_ovf[0] || out_count !== CW'(m_cnt))
          begin n_err++; $display("FAIL rnd%0d_result got vld=%b sum=%0d ovf=%b cnt=%0d want 1/%0d/%0d/%0d",
                                  k, out_valid, out_sum, out_overflow, out_count, es, m_ovf, m_cnt); end
        if (s < stall) begin
          in_valid = $urandom_range(0, 1); in_data = W'($urandom); in_last = 1'b1;
          @(negedge clk);
          in_valid = 1'b0; in_last = 1'b0;
        end
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
